// File: rtl/fwd_scoreboard.sv
// fwd_scoreboard: operand-forwarding and load-use interlock tracker.
// Keeps {v, rd, isload} for each of DEPTH stages after decode, picks the
// youngest ready producer per decode operand and stalls decode when the
// youngest producer's result is not yet available.
module fwd_scoreboard #(
    parameter int XLEN     = 32,
    parameter int AW       = 5,
    parameter int DEPTH    = 3,
    parameter int LD_READY = 2,
    parameter int CNTW     = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    id_valid,
    input  logic [AW-1:0]           id_rs1,
    input  logic [AW-1:0]           id_rs2,
    input  logic                    id_rs1_used,
    input  logic                    id_rs2_used,
    input  logic [AW-1:0]           id_rd,
    input  logic                    id_regwr,
    input  logic                    id_isload,
    input  logic [XLEN-1:0]         rf_rs1o,
    input  logic [XLEN-1:0]         rf_rs2o,
    input  logic [DEPTH*XLEN-1:0]   stg_data,
    input  logic                    hold,
    input  logic                    flush,
    output logic [XLEN-1:0]         rs1_val,
    output logic [XLEN-1:0]         rs2_val,
    output logic [3:0]              rs1_src,
    output logic [3:0]              rs2_src,
    output logic                    id_stall,
    output logic [CNTW-1:0]         stall_cnt
);

    logic [DEPTH-1:0] ent_v;
    logic [DEPTH-1:0] ent_ld;
    logic [AW-1:0]    ent_rd [DEPTH];

    logic             hit1, hit2;
    logic             rdy1, rdy2;
    logic [3:0]       sel1, sel2;
    logic [XLEN-1:0]  fwd1, fwd2;
    logic             hazard;
    logic             enter;

    // Operand lookup: scan oldest to youngest so the youngest match wins.
    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        rdy1 = 1'b0;
        rdy2 = 1'b0;
        sel1 = 4'd0;
        sel2 = 4'd0;
        fwd1 = '0;
        fwd2 = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (ent_v[k] && ent_rd[k] == id_rs1 && id_rs1 != '0 && id_rs1_used) begin
                hit1 = 1'b1;
                rdy1 = !ent_ld[k] || (k >= LD_READY);
                sel1 = 4'(k + 1);
                fwd1 = stg_data[k*XLEN +: XLEN];
            end
            if (ent_v[k] && ent_rd[k] == id_rs2 && id_rs2 != '0 && id_rs2_used) begin
                hit2 = 1'b1;
                rdy2 = !ent_ld[k] || (k >= LD_READY);
                sel2 = 4'(k + 1);
                fwd2 = stg_data[k*XLEN +: XLEN];
            end
        end
    end

    // Output muxing and interlock; a not-ready producer reports the register file.
    always_comb begin
        rs1_val  = (hit1 && rdy1) ? fwd1 : rf_rs1o;
        rs2_val  = (hit2 && rdy2) ? fwd2 : rf_rs2o;
        rs1_src  = (hit1 && rdy1) ? sel1 : 4'd0;
        rs2_src  = (hit2 && rdy2) ? sel2 : 4'd0;
        hazard   = (hit1 && !rdy1) || (hit2 && !rdy2);
        id_stall = id_valid && hazard && !flush;
        enter    = id_valid && !id_stall && !flush && id_regwr && (id_rd != '0);
    end

    // Tracker shift; flush drops the stage-0 entry before it moves on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent_v  <= '0;
            ent_ld <= '0;
            for (int k = 0; k < DEPTH; k++) ent_rd[k] <= '0;
        end else if (!hold) begin
            for (int k = 2; k < DEPTH; k++) begin
                ent_v[k]  <= ent_v[k-1];
                ent_ld[k] <= ent_ld[k-1];
                ent_rd[k] <= ent_rd[k-1];
            end
            ent_v[1]  <= ent_v[0] && !flush;
            ent_ld[1] <= ent_ld[0] && !flush;
            ent_rd[1] <= flush ? '0 : ent_rd[0];
            ent_v[0]  <= enter;
            ent_ld[0] <= enter && id_isload;
            ent_rd[0] <= enter ? id_rd : '0;
        end
    end

    // Saturating count of real stall cycles (frozen while the pipe is held).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (id_stall && !hold && stall_cnt != {CNTW{1'b1}}) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_fwd_scoreboard.sv
// tb_fwd_scoreboard: directed scenarios for the forwarding scoreboard.
// A second instance with a narrow counter shares the stimulus so that
// counter saturation can be reached in a short run.
module tb_fwd_scoreboard;

    localparam int XLEN = 32;
    localparam int AW   = 5;
    localparam int D    = 3;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               id_valid = 1'b0;
    logic [AW-1:0]      id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic               id_rs1_used = 1'b0, id_rs2_used = 1'b0;
    logic               id_regwr = 1'b0, id_isload = 1'b0;
    logic [XLEN-1:0]    rf1 = 32'h1111_0001, rf2 = 32'h2222_0002;
    logic [D*XLEN-1:0]  stg = {32'hC0DE_0002, 32'hC0DE_0001, 32'hC0DE_0000};
    logic               hold = 1'b0, flush = 1'b0;

    logic [XLEN-1:0]    rs1_val, rs2_val, s_rs1_val, s_rs2_val;
    logic [3:0]         rs1_src, rs2_src, s_rs1_src, s_rs2_src;
    logic               id_stall, s_id_stall;
    logic [15:0]        stall_cnt;
    logic [3:0]         s_stall_cnt;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    fwd_scoreboard #(.XLEN(XLEN), .AW(AW), .DEPTH(D), .LD_READY(2), .CNTW(16)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rd(id_rd), .id_regwr(id_regwr), .id_isload(id_isload),
        .rf_rs1o(rf1), .rf_rs2o(rf2), .stg_data(stg),
        .hold(hold), .flush(flush),
        .rs1_val(rs1_val), .rs2_val(rs2_val),
        .rs1_src(rs1_src), .rs2_src(rs2_src),
        .id_stall(id_stall), .stall_cnt(stall_cnt)
    );

    fwd_scoreboard #(.XLEN(XLEN), .AW(AW), .DEPTH(D), .LD_READY(2), .CNTW(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rd(id_rd), .id_regwr(id_regwr), .id_isload(id_isload),
        .rf_rs1o(rf1), .rf_rs2o(rf2), .stg_data(stg),
        .hold(hold), .flush(flush),
        .rs1_val(s_rs1_val), .rs2_val(s_rs2_val),
        .rs1_src(s_rs1_src), .rs2_src(s_rs2_src),
        .id_stall(s_id_stall), .stall_cnt(s_stall_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a decode instruction and let the combinational outputs settle.
    task automatic drv(input logic v, input logic [AW-1:0] r1, input logic u1,
                       input logic [AW-1:0] r2, input logic u2,
                       input logic [AW-1:0] rd, input logic wr, input logic ld);
        id_valid = v; id_rs1 = r1; id_rs1_used = u1; id_rs2 = r2; id_rs2_used = u2;
        id_rd = rd; id_regwr = wr; id_isload = ld;
        #1;
    endtask

    task automatic idle();
        drv(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        idle();
        repeat (D) tick();
    endtask

    task automatic test_reset();
        drv(1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 5'd7, 1'b1, 1'b0);
        total++;
        if (rs1_src !== 4'd0 || rs2_src !== 4'd0 || id_stall !== 1'b0)
            $display("FAIL reset_outputs src1=%0d src2=%0d stall=%0b required 0/0/0", rs1_src, rs2_src, id_stall);
        else passed++;
        total++;
        if (rs1_val !== rf1 || stall_cnt !== 16'd0)
            $display("FAIL reset_val rs1_val=%h cnt=%0d required %h/0", rs1_val, stall_cnt, rf1);
        else passed++;
        idle();
        #2 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_alu_chain();
        drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
        tick();
        stg[0 +: XLEN] = 32'h0000_1234;
        drv(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        total++;
        if (rs1_val !== 32'h1234 || rs1_src !== 4'd1 || id_stall !== 1'b0)
            $display("FAIL alu_fwd val=%h src=%0d stall=%0b required 1234/1/0", rs1_val, rs1_src, id_stall);
        else passed++;
        drain();
    endtask

    task automatic test_load_use();
        stg[2*XLEN +: XLEN] = 32'hDEAD_0007;
        drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);
        tick();
        drv(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0);
        total++;
        if (id_stall !== 1'b1) $display("FAIL loaduse_stall1 stall=%0b required 1", id_stall);
        else passed++;
        tick();
        total++;
        if (id_stall !== 1'b1 || stall_cnt !== 16'd1)
            $display("FAIL loaduse_stall2 stall=%0b cnt=%0d required 1/1", id_stall, stall_cnt);
        else passed++;
        tick();
        total++;
        if (id_stall !== 1'b0 || rs1_src !== 4'd3 || rs1_val !== 32'hDEAD_0007 || stall_cnt !== 16'd2)
            $display("FAIL loaduse_fwd stall=%0b src=%0d val=%h cnt=%0d required 0/3/dead0007/2",
                     id_stall, rs1_src, rs1_val, stall_cnt);
        else passed++;
        drain();
        // one independent instruction between load and consumer
        drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);
        tick();
        idle();
        tick();
        drv(1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0);
        total++;
        if (id_stall !== 1'b1) $display("FAIL gap1_stall stall=%0b required 1", id_stall);
        else passed++;
        tick();
        total++;
        if (id_stall !== 1'b0 || rs2_src !== 4'd3 || stall_cnt !== 16'd3)
            $display("FAIL gap1_fwd stall=%0b src=%0d cnt=%0d required 0/3/3", id_stall, rs2_src, stall_cnt);
        else passed++;
        drain();
    endtask

    task automatic test_reset_midrun();
        drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd1, 1'b1, 1'b0); tick();
        drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd2, 1'b1, 1'b0); tick();
        drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1); tick();
        drv(1'b1, 5'd3, 1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 1'b0);
        total++;
        if (id_stall !== 1'b1 || rs2_src !== 4'd2)
            $display("FAIL midrun_pre stall=%0b src2=%0d required 1/2", id_stall, rs2_src);
        else passed++;
        rst_n = 1'b0;
        #1;
        total++;
        if (id_stall !== 1'b0 || rs1_src !== 4'd0 || rs2_src !== 4'd0 || stall_cnt !== 16'd0 || rs1_val !== rf1)
            $display("FAIL midrun_reset stall=%0b src1=%0d src2=%0d cnt=%0d val=%h required 0/0/0/0/%h",
                     id_stall, rs1_src, rs2_src, stall_cnt, rs1_val, rf1);
        else passed++;
        idle();
        tick();
        rst_n = 1'b1;
        #1;
        drv(1'b1, 5'd3, 1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b0);
        total++;
        if (id_stall !== 1'b0 || rs1_src !== 4'd0 || rs2_src !== 4'd0)
            $display("FAIL midrun_after stall=%0b src1=%0d src2=%0d required 0/0/0", id_stall, rs1_src, rs2_src);
        else passed++;
        drain();
    endtask

    task automatic test_x0_unused();
        drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);
        tick();
        drv(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0);
        total++;
        if (id_stall !== 1'b0 || rs1_src !== 4'd0 || rs1_val !== rf1)
            $display("FAIL x0_dest stall=%0b src=%0d val=%h required 0/0/%h", id_stall, rs1_src, rs1_val, rf1);
        else passed++;
        tick();
        drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1);
        tick();
        drv(1'b1, 5'd0, 1'b0, 5'd9, 1'b0, 5'd0, 1'b0, 1'b0);
        total++;
        if (id_stall !== 1'b0 || rs2_src !== 4'd0 || rs2_val !== rf2)
            $display("FAIL unused_op stall=%0b src=%0d val=%h required 0/0/%h", id_stall, rs2_src, rs2_val, rf2);
        else passed++;
        drain();
    endtask

    task automatic test_youngest();
        stg[0 +: XLEN]      = 32'h0000_BBBB;
        stg[2*XLEN +: XLEN] = 32'h0000_AAAA;
        drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0); tick();
        idle(); tick();
        drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0); tick();
        drv(1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0);
        total++;
        if (rs2_val !== 32'h0000_BBBB || rs2_src !== 4'd1 || id_stall !== 1'b0)
            $display("FAIL youngest_alu val=%h src=%0d stall=%0b required bbbb/1/0", rs2_val, rs2_src, id_stall);
        else passed++;
        drain();
        drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0); tick();
        idle(); tick();
        drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1); tick();
        drv(1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0);
        total++;
        if (id_stall !== 1'b1 || rs2_src !== 4'd0)
            $display("FAIL youngest_load stall=%0b src=%0d required 1/0", id_stall, rs2_src);
        else passed++;
        drain();
    endtask

    task automatic test_flush();
        drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1);
        tick();
        flush = 1'b1;
        drv(1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0);
        total++;
        if (id_stall !== 1'b0) $display("FAIL flush_wins stall=%0b required 0", id_stall);
        else passed++;
        tick();
        flush = 1'b0;
        drv(1'b1, 5'd4, 1'b1, 5'd10, 1'b1, 5'd0, 1'b0, 1'b0);
        total++;
        if (id_stall !== 1'b0 || rs1_src !== 4'd0 || rs2_src !== 4'd0)
            $display("FAIL flush_drop stall=%0b src1=%0d src2=%0d required 0/0/0", id_stall, rs1_src, rs2_src);
        else passed++;
        tick();
        total++;
        if (rs1_src !== 4'd0 || stall_cnt !== 16'd0)
            $display("FAIL flush_later src=%0d cnt=%0d required 0/0", rs1_src, stall_cnt);
        else passed++;
        drain();
    endtask

    task automatic test_hold();
        stg[2*XLEN +: XLEN] = 32'h0000_6666;
        drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1);
        tick();
        drv(1'b1, 5'd6, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        hold = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) begin
            flush = (i == 2);
            tick();
            flush = 1'b0;
            #1;
            total++;
            if (id_stall !== 1'b1 || stall_cnt !== 16'd0)
                $display("FAIL hold_frozen cyc=%0d stall=%0b cnt=%0d required 1/0", i, id_stall, stall_cnt);
            else passed++;
        end
        hold = 1'b0;
        tick();
        tick();
        total++;
        if (id_stall !== 1'b0 || rs1_src !== 4'd3 || rs1_val !== 32'h0000_6666 || stall_cnt !== 16'd2)
            $display("FAIL hold_resume stall=%0b src=%0d val=%h cnt=%0d required 0/3/6666/2",
                     id_stall, rs1_src, rs1_val, stall_cnt);
        else passed++;
        drain();
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 10; i++) begin
            drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);
            tick();
            drv(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
            tick();
            tick();
        end
        idle();
        total++;
        if (stall_cnt !== 16'd22)
            $display("FAIL sat_wide cnt=%0d required 22", stall_cnt);
        else passed++;
        total++;
        if (s_stall_cnt !== 4'hF)
            $display("FAIL sat_narrow cnt=%0d required 15", s_stall_cnt);
        else passed++;
        drain();
    endtask

    initial begin
        test_reset();
        test_alu_chain();
        test_load_use();
        test_reset_midrun();
        test_x0_unused();
        test_youngest();
        test_flush();
        test_hold();
        test_saturate();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fwd_scoreboard.md
# fwd_scoreboard

Parametrised operand-forwarding and interlock unit for the next-generation in-order pipeline. It tracks destination registers in flight across DEPTH stages after decode, selects the youngest ready producer for each decode operand, and raises a decode stall on load-use or other not-yet-ready hazards. It sits beside the decode stage and replaces the fixed three-stage forwarding mux pair and combinational hazard block with a sequential, stall- and flush-aware tracker.

## Interface
- XLEN, 32, datapath width
- AW, 5, register address width (2^AW architectural registers; register 0 hard-wired zero)
- DEPTH, 3, tracked stages after decode (index 0 = EX, DEPTH-1 = WB); legal range 2..8
- LD_READY, 2, first stage index at which a load result is valid; legal range 1..DEPTH-1
- CNTW, 16, width of the stall performance counter
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  decode holds a real instruction
- id_rs1, id_rs2  in  AW each  source register addresses
- id_rs1_used, id_rs2_used  in  1 each  operand actually read
- id_rd  in  AW  destination address
- id_regwr  in  1  instruction writes id_rd
- id_isload  in  1  result comes from data memory
- rf_rs1o, rf_rs2o  in  XLEN each  register-file read data
- stg_data  in  DEPTH*XLEN  per-stage result data; stage k at bits [k*XLEN +: XLEN]
- hold  in  1  whole-pipeline freeze (memory wait)
- flush  in  1  kill the decode instruction and the stage-0 entry (taken branch/jump)
- rs1_val, rs2_val  out  XLEN each  forwarded operand values
- rs1_src, rs2_src  out  4 each  source: 0 = register file, k+1 = stage k
- id_stall  out  1  hold IF/ID, insert bubble into stage 0
- stall_cnt  out  CNTW  saturating count of cycles with id_stall=1 and hold=0

## Operation
- Tracker: DEPTH entries, each {v, rd, isload}; v set only for id_regwr=1 with id_rd != 0.
- Match at stage k for operand s: entry v=1, rd == id_rs_s, id_rs_s != 0, id_rs_s_used=1.
- Youngest match (lowest k) wins; older matches ignored.
- Ready at stage k: isload=0, or k >= LD_READY.
- Winning match ready: rs_val = stg_data stage k, rs_src = k+1. No match: rs_val = rf value, rs_src = 0.
- id_stall = id_valid & (either used operand's winning match not ready) & ~flush.
- Advance (hold=0): entry k+1 <- entry k for all k; entry 0 <- decode instruction if id_valid & ~id_stall & ~flush, else bubble (v=0).
- flush with hold=0: decode instruction not entered; entry 0 also cleared before shift (stage-1 receives bubble).
- hold=1: all entries frozen, stall_cnt frozen, flush ignored; outputs still combinationally valid.
- Entry DEPTH-1 is shifted out; the register file is then authoritative (write at same edge, reads in next cycle).
- stall_cnt increments when id_stall=1 & hold=0, saturates at all-ones.

## Timing
- rs*_val, rs*_src, id_stall: combinational from inputs and tracker state, same cycle.
- Tracker and stall_cnt update on rising clk.
- Reset (async, rst_n=0): all v=0, rd=0, isload=0, stall_cnt=0; hence id_stall=0, rs*_src=0, rs*_val = rf values. Deassertion is synchronised externally; first update at first rising edge with rst_n=1.
- Load-use with LD_READY=2, DEPTH=3: consumer directly after load stalls 2 cycles, forwards from stage 2 on third cycle; one instruction gap → 1 stall cycle; two gaps → 0.
- ALU dependency: zero stall, forwarded from stage 0.
- Simultaneous flush and stall condition: flush wins, id_stall=0.
- Same rd in two stages: youngest wins even if older is ready and younger is not (stall).

## Test plan
- Reset mid-run with three valid entries, rst_n low one cycle → all v=0, stall_cnt=0, rs1_src=0 immediately without clock.
- ALU chain: write x5 then read x5 next cycle, stg_data[0]=0x1234 → rs1_val=0x1234, rs1_src=1, id_stall=0.
- Load-use: load x7 then add reading x7 → id_stall=1 two cycles, third cycle rs1_src=3, rs1_val=stg_data stage 2, stall_cnt=2.
- x0 destination and unused operand: load x0 then read x0; load x9 with id_rs2=9, id_rs2_used=0 → no stall, src=0.
- Youngest priority: ALU x3 at stage 2 (0xAAAA), ALU x3 at stage 0 (0xBBBB) → rs2_val=0xBBBB, rs2_src=1.
- Flush/hold: load x4 in stage 0 then flush → entry dropped, later x4 read forwards nothing (src=0); hold=1 for 5 cycles during a stall → tracker and stall_cnt unchanged, stall_cnt saturates at 0xFFFF under continuous stall.
